// File: rtl/tick_pwm_if.sv
`default_nettype none
// ============================================================================
//  Module   : tick_pwm_if
//  Purpose  : Control/status bundle for tick_pwm. The master drives the tick,
//             enable and period/duty write. The slave (tick_pwm) returns the
//             PWM output and its status strobes.
//  Revision : 1.0  initial release
// ============================================================================
interface tick_pwm_if #(
    parameter int WIDTH = 8
);
    logic             i_tick;
    logic             i_en;
    logic             i_wr;
    logic [WIDTH-1:0] i_period;
    logic [WIDTH-1:0] i_duty;
    logic             o_pwm;
    logic             o_period_end;
    logic             o_pending;

    modport master (
        output i_tick, i_en, i_wr, i_period, i_duty,
        input  o_pwm, o_period_end, o_pending
    );

    modport slave (
        input  i_tick, i_en, i_wr, i_period, i_duty,
        output o_pwm, o_period_end, o_pending
    );
endinterface
`default_nettype wire

// File: rtl/tick_pwm.sv
`default_nettype none
// ============================================================================
//  Module   : tick_pwm
//  Purpose  : PWM generator using an external one-cycle tick as its timebase.
//             Period and duty are double-buffered. Writes land in shadow
//             registers and take effect only at a period boundary or on
//             leaving IDLE, so the waveform never glitches.
//  Revision : 1.0  initial release
// ============================================================================
module tick_pwm #(
    parameter int WIDTH = 8
) (
    input  logic        i_clk,
    input  logic        inner_rst_n,
    tick_pwm_if.slave   bus
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_sh_period;
    logic [WIDTH-1:0] r_sh_duty;
    logic [WIDTH-1:0] r_act_period;
    logic [WIDTH-1:0] r_act_duty;
    logic             r_pwm;
    logic             r_period_end;
    logic             r_pending;

    // r_cnt stays below r_act_period whenever this value is used, so the
    // increment cannot wrap.
    logic [WIDTH-1:0] w_cnt_inc;
    assign w_cnt_inc = r_cnt + 1'b1;

    assign bus.o_pwm        = r_pwm;
    assign bus.o_period_end = r_period_end;
    assign bus.o_pending    = r_pending;

    // Shadow capture, run/idle control, tick counting and boundary reload.
    always_ff @(posedge i_clk or negedge inner_rst_n) begin
        if (!inner_rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_sh_period  <= '1;
            r_sh_duty    <= '0;
            r_act_period <= '1;
            r_act_duty   <= '0;
            r_pwm        <= 1'b0;
            r_period_end <= 1'b0;
            r_pending    <= 1'b0;
        end else begin
            r_period_end <= 1'b0;

            // A write is accepted in every state. Later assignments below that
            // clear r_pending are guarded by !i_wr, so a same-edge write stays
            // pending.
            if (bus.i_wr) begin
                r_sh_period <= bus.i_period;
                r_sh_duty   <= bus.i_duty;
                r_pending   <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    r_pwm <= 1'b0;
                    // The tick is ignored on the entry edge. The count starts
                    // at 0 with the pre-edge shadow made active.
                    if (bus.i_en) begin
                        r_state      <= ST_RUN;
                        r_act_period <= r_sh_period;
                        r_act_duty   <= r_sh_duty;
                        r_pwm        <= (r_sh_duty != '0);
                        if (!bus.i_wr) begin
                            r_pending <= 1'b0;
                        end
                    end
                end

                ST_RUN: begin
                    if (!bus.i_en) begin
                        // Stop takes priority over a coincident tick or
                        // boundary.
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        r_pwm   <= 1'b0;
                    end else if (bus.i_tick) begin
                        if (r_cnt == r_act_period) begin
                            r_cnt        <= '0;
                            r_period_end <= 1'b1;
                            if (r_pending) begin
                                r_act_period <= r_sh_period;
                                r_act_duty   <= r_sh_duty;
                                r_pwm        <= (r_sh_duty != '0);
                                if (!bus.i_wr) begin
                                    r_pending <= 1'b0;
                                end
                            end else begin
                                r_pwm <= (r_act_duty != '0);
                            end
                        end else begin
                            r_cnt <= w_cnt_inc;
                            r_pwm <= (w_cnt_inc < r_act_duty);
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
